// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared count-width helper and output mode type for stream_fifo
package stream_fifo_pkg;
  typedef enum logic {FIFO_REGISTERED = 1'b0, FIFO_FALLTHROUGH = 1'b1} fifo_mode_e;
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/stream_fifo_ptr.sv
// stream_fifo_ptr: modulo-DEPTH pointer with increment, synchronous clear and explicit wrap
module stream_fifo_ptr #(
  parameter int DEPTH = 5,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with optional fall-through, flush, count and almost flags.
// Define STREAM_FIFO_STATS_EN to add the max_count high-water-mark port.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int BYPASS = 0,
  localparam int CW = clog2_depth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush,
  input  logic [ELEM_WIDTH-1:0] data_in,
  input  logic                  data_in_val,
  output logic                  data_in_rdy,
  output logic [ELEM_WIDTH-1:0] data_out,
  output logic                  data_out_val,
  input  logic                  data_out_rdy,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef STREAM_FIFO_STATS_EN
  ,
  output logic [CW-1:0]         max_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (BYPASS != 0) ? FIFO_FALLTHROUGH : FIFO_REGISTERED;
  logic [ELEM_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic full, empty, bypass, push, pop, wr_en, rd_en;
  // In fall-through, an empty FIFO presents data_in directly; it is only stored if not taken.
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    bypass = MODE == FIFO_FALLTHROUGH && empty && data_in_val && !flush;
    data_in_rdy = !full && !flush;
    data_out_val = !flush && (!empty || bypass);
    data_out = bypass ? data_in : mem[rd_ptr];
    push = data_in_val && data_in_rdy;
    pop = data_out_val && data_out_rdy;
    wr_en = push && !(bypass && data_out_rdy);
    rd_en = pop && !empty;
    count_nxt = flush ? '0 : count + CW'(wr_en) - CW'(rd_en);
    almost_full = count >= CW'(AFULL_THRESH);
    almost_empty = count <= CW'(AEMPTY_THRESH);
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) count <= '0;
    else count <= count_nxt;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= data_in;
  stream_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .arst_n(arst_n), .clr(flush), .inc(wr_en), .ptr(wr_ptr)
  );
  stream_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .arst_n(arst_n), .clr(flush), .inc(rd_en), .ptr(rd_ptr)
  );
`ifdef STREAM_FIFO_STATS_EN
  // High-water mark survives flush; only reset clears it.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) max_count <= '0;
    else if (count_nxt > max_count) max_count <= count_nxt;
`endif
`ifndef SYNTHESIS
  if (DEPTH < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_params
    $error("stream_fifo: illegal parameter combination");
  end
  a_no_push_full: assert property (@(posedge clk) disable iff (!arst_n) !(push && full));
  a_out_stable: assert property (@(posedge clk) disable iff (!arst_n)
    data_out_val && !data_out_rdy && !flush |=> !data_out_val || $stable(data_out));
`endif
endmodule
